// File: rtl/m_axi_cmd.sv
// Single-outstanding AXI requester: turns one register command into an AW/W/B or AR/R
// exchange and reports the result as a one-cycle response. Optional watchdog: M_AXI_CMD_TIMEOUT_EN.
module m_axi_cmd #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
    output logic [ID_W-1:0]       awid_o,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [ID_W-1:0]       arid_o,
    output logic [ADDR_W-1:0]     araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic                  rsp_valid_o,
    output logic                  rsp_we_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic [1:0]            rsp_resp_o
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                aw_pend, w_pend;
    logic                timeout_hit;

    // A channel is still pending if its valid is up and this cycle brings no ready.
    assign aw_pend = awvalid_q & ~awready_i;
    assign w_pend  = wvalid_q & ~wready_i;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    wstrb_d = cmd_wstrb_i;
                    we_d    = cmd_we_i;
                    rdata_d = '0;
                    resp_d  = 2'b00;
                    if (cmd_we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                awvalid_d = aw_pend;
                wvalid_d  = w_pend;
                if (!aw_pend && !w_pend) begin
                    state_d = S_WR_RESP;
                end else if (timeout_hit) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    resp_d    = 2'b10;
                    state_d   = S_RSP;
                end
            end
            S_WR_RESP: begin
                if (bvalid_i) begin
                    resp_d  = bresp_i;
                    state_d = S_RSP;
                end else if (timeout_hit) begin
                    resp_d  = 2'b10;
                    state_d = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (arready_i) begin
                    state_d = S_RD_DATA;
                end else if (timeout_hit) begin
                    resp_d  = 2'b10;
                    state_d = S_RSP;
                end
            end
            S_RD_DATA: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i;
                    state_d = S_RSP;
                end else if (timeout_hit) begin
                    resp_d  = 2'b10;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                id_d    = id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef M_AXI_CMD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             waiting;

    assign waiting     = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                         (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    assign timeout_hit = waiting && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counts cycles spent in the current wait state; restarts on every transition.
    always_comb begin
        to_cnt_d = '0;
        if (waiting && (state_d == state_q)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // Ready is held low for as long as reset is applied, not only once it is sampled.
    assign cmd_ready_o = (state_q == S_IDLE) && areset;
    assign awid_o      = id_q;
    assign arid_o      = id_q;
    assign awaddr_o    = addr_q;
    assign araddr_o    = addr_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = (state_q == S_WR_RESP);
    assign arvalid_o   = (state_q == S_RD_ADDR);
    assign rready_o    = (state_q == S_RD_DATA);
    assign rsp_valid_o = (state_q == S_RSP);
    assign rsp_we_o    = we_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;
endmodule

// File: tb/tb_m_axi_cmd.sv
// Scoreboard bench for m_axi_cmd: a randomized AXI slave model, a command driver that
// queues expected responses, and an independent monitor that checks every channel.
`timescale 1ns/1ps
module tb_m_axi_cmd;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = 4;
`ifdef M_AXI_CMD_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 256;
`endif

    logic              clk = 1'b0;
    logic              areset = 1'b0;
    logic              cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [STRB_W-1:0] cmd_wstrb_i;
    logic [ID_W-1:0]   awid_o, arid_o;
    logic [ADDR_W-1:0] awaddr_o, araddr_o;
    logic              awvalid_o, awready_i, wvalid_o, wready_i;
    logic [DATA_W-1:0] wdata_o, rdata_i, rsp_rdata_o;
    logic [STRB_W-1:0] wstrb_o;
    logic [1:0]        bresp_i, rsp_resp_o;
    logic              bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;
    logic              rsp_valid_o, rsp_we_o;

    always #5 clk = ~clk;

    m_axi_cmd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  id;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          acc;
        int          lat;
        bit          to;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [3:0]  model_id = 4'd0;
    int          clear_req = 0;
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  k_bresp = 2'b00;
    logic [31:0] k_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Slave model: per-transaction ready/valid delays taken from the knobs above.
    initial begin : slave
        bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
        bit aw_done, w_done, ar_done;
        int aw_c, w_c, b_c, ar_c, r_c, clear_ack;
        aw_done = 0; w_done = 0; ar_done = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; clear_ack = 0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
        arready_i = 0; rvalid_i = 0; rdata_i = 0;
        forever begin
            @(negedge clk);
            hs_aw = awvalid_o && awready_i;
            hs_w  = wvalid_o && wready_i;
            hs_b  = bvalid_i && bready_o;
            hs_ar = arvalid_o && arready_i;
            hs_r  = rvalid_i && rready_o;
            @(posedge clk); #1;
            if (!areset || clear_ack != clear_req) begin
                clear_ack = clear_req;
                aw_done = 0; w_done = 0; ar_done = 0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
            end else begin
                if (hs_aw) begin awready_i = 0; aw_done = 1; aw_c = 0; end
                if (hs_w)  begin wready_i = 0;  w_done = 1;  w_c = 0;  end
                if (hs_b)  begin bvalid_i = 0;  aw_done = 0; w_done = 0; b_c = 0; end
                if (hs_ar) begin arready_i = 0; ar_done = 1; ar_c = 0; end
                if (hs_r)  begin rvalid_i = 0;  ar_done = 0; r_c = 0;  end
                if (awvalid_o && !awready_i && !aw_done) begin
                    if (aw_c >= aw_dly) awready_i = 1; else aw_c++;
                end
                if (wvalid_o && !wready_i && !w_done) begin
                    if (w_c >= w_dly) wready_i = 1; else w_c++;
                end
                if (aw_done && w_done && !bvalid_i) begin
                    if (b_c >= b_dly) begin bvalid_i = 1; bresp_i = k_bresp; end else b_c++;
                end
                if (arvalid_o && !arready_i && !ar_done) begin
                    if (ar_c >= ar_dly) arready_i = 1; else ar_c++;
                end
                if (ar_done && !rvalid_i) begin
                    if (r_c >= r_dly) begin rvalid_i = 1; rdata_i = k_rdata; end else r_c++;
                end
            end
            if (!rvalid_i) rdata_i = $urandom;
            if (!bvalid_i) bresp_i = 2'($urandom);
        end
    end

    // Monitor: channel contents, valid hold/drop rules, and response scoreboard.
    initial begin : monitor
        bit          p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs, skip_hold;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        int          n_aw, n_w, n_ar;
        exp_t        e;
        p_awv = 0; p_aw_hs = 0; p_wv = 0; p_w_hs = 0; p_arv = 0; p_ar_hs = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
        n_aw = 0; n_w = 0; n_ar = 0;
        forever begin
            @(negedge clk);
            if (!areset) begin
                p_awv = 0; p_aw_hs = 0; p_wv = 0; p_w_hs = 0; p_arv = 0; p_ar_hs = 0;
                n_aw = 0; n_w = 0; n_ar = 0;
            end else begin
                skip_hold = (exp_q.size() > 0) && exp_q[0].to;
                chk("cmd_ready_vs_busy", 64'(cmd_ready_o), 64'(exp_q.size() == 0));
                if (p_aw_hs) chk("aw_drop", 64'(awvalid_o), 64'(0));
                else if (p_awv && !skip_hold)
                    chk("aw_hold", 64'({awvalid_o, awaddr_o}), 64'({1'b1, p_awaddr}));
                if (p_w_hs) chk("w_drop", 64'(wvalid_o), 64'(0));
                else if (p_wv && !skip_hold)
                    chk("w_hold", 64'({wvalid_o, wstrb_o, wdata_o}), 64'({1'b1, p_wstrb, p_wdata}));
                if (p_ar_hs) chk("ar_drop", 64'(arvalid_o), 64'(0));
                else if (p_arv && !skip_hold)
                    chk("ar_hold", 64'({arvalid_o, araddr_o}), 64'({1'b1, p_araddr}));
                if (awvalid_o && awready_i) begin
                    n_aw++;
                    chk("aw_outstanding", 64'(exp_q.size()), 64'(1));
                    if (exp_q.size() > 0) begin
                        chk("awaddr", 64'(awaddr_o), 64'(exp_q[0].addr));
                        chk("awid", 64'(awid_o), 64'(exp_q[0].id));
                    end
                end
                if (wvalid_o && wready_i) begin
                    n_w++;
                    chk("w_outstanding", 64'(exp_q.size()), 64'(1));
                    if (exp_q.size() > 0)
                        chk("wdata_wstrb", 64'({wstrb_o, wdata_o}), 64'({exp_q[0].wstrb, exp_q[0].wdata}));
                end
                if (arvalid_o && arready_i) begin
                    n_ar++;
                    chk("ar_outstanding", 64'(exp_q.size()), 64'(1));
                    if (exp_q.size() > 0) begin
                        chk("araddr", 64'(araddr_o), 64'(exp_q[0].addr));
                        chk("arid", 64'(arid_o), 64'(exp_q[0].id));
                    end
                end
                if (rsp_valid_o) begin
                    chk("rsp_outstanding", 64'(exp_q.size()), 64'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_we", 64'(rsp_we_o), 64'(e.we));
                        chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                        chk("rsp_resp", 64'(rsp_resp_o), 64'(e.resp));
                        chk("rsp_bus_idle", 64'({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}), 64'(0));
                        if (e.lat > 0) chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                        chk("aw_count", 64'(n_aw), 64'(e.we && !e.to));
                        chk("w_count", 64'(n_w), 64'(e.we && !e.to));
                        chk("ar_count", 64'(n_ar), 64'(!e.we && !e.to));
                        $display("rsp id=%0d we=%0d addr=%08h rdata=%08h resp=%0d cyc=%0d",
                                 e.id, rsp_we_o, e.addr, rsp_rdata_o, rsp_resp_o, cyc - e.acc);
                    end
                    n_aw = 0; n_w = 0; n_ar = 0;
                end
                p_awv = awvalid_o; p_aw_hs = awvalid_o && awready_i; p_awaddr = awaddr_o;
                p_wv = wvalid_o;   p_w_hs = wvalid_o && wready_i;    p_wdata = wdata_o; p_wstrb = wstrb_o;
                p_arv = arvalid_o; p_ar_hs = arvalid_o && arready_i; p_araddr = araddr_o;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [1:0] bresp, input logic [31:0] rdata,
                         input int d_aw, input int d_w, input int d_b, input int d_ar, input int d_r,
                         input bit zero_wait, input bit to);
        exp_t e;
        int   n;
        n = 0;
        while (!cmd_ready_o && n < 300) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_wait", 64'(cmd_ready_o), 64'(1));
        aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
        k_bresp = bresp; k_rdata = rdata;
        cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_wstrb_i = wstrb;
        @(negedge clk);
        e.acc = cyc;
        e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.id = model_id; e.to = to;
        e.rdata = (we || to) ? 32'h0 : rdata;
        e.resp  = to ? 2'b10 : (we ? bresp : 2'b00);
        e.lat   = to ? TO_CYC + 1 : (zero_wait ? 3 : 0);
        @(posedge clk); #1;
        cmd_valid_i = 0;
        cmd_we_i = 1'($urandom); cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_wstrb_i = 4'($urandom);
        exp_q.push_back(e);
        model_id = model_id + 4'd1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin @(posedge clk); #1; n++; end
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : driver
        int n;
        logic we;
        cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0; cmd_wstrb_i = 0;
        areset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
        chk("rst_valids", 64'({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}), 64'(0));
        chk("rst_awaddr", 64'(awaddr_o), 64'(0));
        chk("rst_araddr", 64'(araddr_o), 64'(0));
        chk("rst_wdata_wstrb", 64'({wstrb_o, wdata_o}), 64'(0));
        chk("rst_rsp", 64'({rsp_resp_o, rsp_rdata_o}), 64'(0));
        chk("rst_ids", 64'({awid_o, arid_o}), 64'(0));
        areset = 1;
        @(posedge clk); #1;

        issue(1'b1, 32'hA3DD0001, 32'hC2AAEE2A, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        drain();
        issue(1'b1, 32'h0000_1234, 32'h5A5A_0F0F, 4'h6, 2'b00, 32'h0, 4, 0, 0, 0, 0, 1'b0, 1'b0);
        drain();
        issue(1'b0, 32'hA3DD0001, 32'h0, 4'h0, 2'b00, 32'h7778111A, 0, 0, 0, 0, 3, 1'b0, 1'b0);
        drain();

        // Reset while the read is waiting for R: nothing may be reported for it.
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF, 0, 0, 0, 0, 1000, 1'b0, 1'b0);
        n = 0;
        while (!rready_o && n < 50) begin @(posedge clk); #1; n++; end
        chk("reached_rd_data", 64'(rready_o), 64'(1));
        areset = 0;
        #1;
        chk("midrst_ar_r", 64'({arvalid_o, rready_o}), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'(0));
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        model_id = 4'd0;
        clear_req++;
        repeat (3) @(posedge clk);
        #1;
        areset = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            we = 1'($urandom);
            issue(we, $urandom, $urandom, 4'($urandom), 2'($urandom), $urandom, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        end
        drain();

        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            issue(we, $urandom, $urandom, 4'($urandom), 2'($urandom), $urandom,
                  $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, 1'b0);
        end
        drain();

`ifdef M_AXI_CMD_TIMEOUT_EN
        issue(1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF, 2'b00, 32'h0, 1000, 1000, 0, 0, 0, 1'b0, 1'b1);
        drain();
        clear_req++;
        @(posedge clk); #1;
        issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 2'b00, 32'h0BAD_CAFE, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
